// File: rtl/ising_pkg.sv
// Shared types and helpers for the Ising run sequencer.
//   state_t     : sequencer FSM states
//   phase_slice : extracts one spin's phase count from the flat phase bus
package ising_pkg;

  localparam int unsigned N_DEF     = 8;
  localparam int unsigned CTR_W_DEF = 32;
  localparam int unsigned RUN_W_DEF = 32;
  localparam int unsigned REP_W_DEF = 4;

  // Upper bounds for the slice helper; callers zero-extend into these widths.
  localparam int unsigned PHASE_BUS_MAX = 4096;
  localparam int unsigned CTR_MAX       = 64;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // Returns bits [idx*w +: w] of bus, zero-extended to CTR_MAX bits.
  function automatic logic [CTR_MAX-1:0] phase_slice(
    input logic [PHASE_BUS_MAX-1:0] bus,
    input int unsigned              idx,
    input int unsigned              w
  );
    logic [PHASE_BUS_MAX-1:0] shifted;
    logic [CTR_MAX-1:0]       mask;
    shifted = bus >> (idx * w);
    mask    = (w >= CTR_MAX) ? '1 : ((CTR_MAX'(1) << w) - CTR_MAX'(1));
    return shifted[CTR_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/ising_vote_ctr.sv
// Per-spin vote counter for the run sequencer.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : zero the vote count (start of a job)
//   inc       : add one vote (spin sampled high)
//   reps      : effective repetition count of the job
//   majority  : 2*votes >  reps
//   tie       : 2*votes == reps
module ising_vote_ctr #(
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [REP_W-1:0] reps,
  output logic             majority,
  output logic             tie
);

  logic [REP_W-1:0] votes;
  logic [REP_W:0]   twice_votes;
  logic [REP_W:0]   reps_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      votes <= '0;
    end else if (clear) begin
      votes <= '0;
    end else if (inc) begin
      votes <= votes + REP_W'(1);
    end
  end

  // Compare at REP_W+1 bits so doubling the count cannot wrap.
  assign twice_votes = {votes, 1'b0};
  assign reps_ext    = {1'b0, reps};
  assign majority    = (twice_votes > reps_ext);
  assign tie         = (twice_votes == reps_ext);

endmodule

// File: rtl/ising_run_sequencer.sv
// Run controller between the register front end and the Ising core.
// Runs the core for a programmed number of cycles, waits a settle period,
// thresholds every spin's phase count, repeats for a number of runs and
// reports a per-spin majority vote.
//   clk, rst           : clock, asynchronous active-high reset
//   start              : one-cycle job request (accepted in IDLE only)
//   abort              : level, returns to IDLE without a done pulse
//   cfg_run_cycles     : core run length per repetition (0 -> 1)
//   cfg_settle_cycles  : idle cycles between stopping the core and sampling
//   cfg_reps           : repetition count (0 -> 1)
//   cfg_cutoff         : phase threshold
//   phase_in           : flat phase counts, spin i at [i*CTR_W +: CTR_W]
//   ising_run          : core run enable, high only in RUN
//   busy               : high outside IDLE
//   done               : one-cycle pulse, results valid
//   spins, ties        : majority result and tie flags
//   last_spins         : thresholded vector of the latest sample
//   rep_idx            : completed repetitions in the current job
module ising_run_sequencer
  import ising_pkg::*;
#(
  parameter int N     = 8,
  parameter int CTR_W = 32,
  parameter int RUN_W = 32,
  parameter int REP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [RUN_W-1:0]   cfg_run_cycles,
  input  logic [RUN_W-1:0]   cfg_settle_cycles,
  input  logic [REP_W-1:0]   cfg_reps,
  input  logic [CTR_W-1:0]   cfg_cutoff,
  input  logic [N*CTR_W-1:0] phase_in,
  output logic               ising_run,
  output logic               busy,
  output logic               done,
  output logic [N-1:0]       spins,
  output logic [N-1:0]       ties,
  output logic [N-1:0]       last_spins,
  output logic [REP_W-1:0]   rep_idx
);

  state_t state, state_next;

  logic [RUN_W-1:0] run_q, settle_q;
  logic [REP_W-1:0] reps_q;
  logic [CTR_W-1:0] cutoff_q;
  logic [RUN_W-1:0] run_cnt, settle_cnt;
  logic [N-1:0]     spins_q, ties_q;
  logic [N-1:0]     sample_bits, maj_vec, tie_vec;
  logic             start_accept;
  logic             sample_en;

  assign start_accept = (state == IDLE) && start && !abort;
  assign sample_en    = (state == SAMPLE) && !abort;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (run_cnt == RUN_W'(1))
                 state_next = (settle_q == '0) ? SAMPLE : SETTLE;
      SETTLE:  if (settle_cnt == '0) state_next = SAMPLE;
      SAMPLE:  state_next = ((rep_idx + REP_W'(1)) == reps_q) ? DONE : RUN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // Output logic. During the DONE cycle the fresh vote result is shown
  // directly; it is captured into spins_q/ties_q for holding afterwards.
  always_comb begin
    ising_run = (state == RUN);
    busy      = (state != IDLE);
    done      = (state == DONE) && !abort;
    spins     = done ? maj_vec : spins_q;
    ties      = done ? tie_vec : ties_q;
  end

  // Datapath: shadow config, run/settle counters, sample and result registers.
  // Settle counter is loaded with S-1 while in RUN so SETTLE lasts S cycles
  // and exits at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q      <= '0;
      settle_q   <= '0;
      reps_q     <= '0;
      cutoff_q   <= '0;
      run_cnt    <= '0;
      settle_cnt <= '0;
      rep_idx    <= '0;
      last_spins <= '0;
      spins_q    <= '0;
      ties_q     <= '0;
    end else if (start_accept) begin
      run_q    <= (cfg_run_cycles == '0) ? RUN_W'(1) : cfg_run_cycles;
      run_cnt  <= (cfg_run_cycles == '0) ? RUN_W'(1) : cfg_run_cycles;
      settle_q <= cfg_settle_cycles;
      reps_q   <= (cfg_reps == '0) ? REP_W'(1) : cfg_reps;
      cutoff_q <= cfg_cutoff;
      rep_idx  <= '0;
    end else if (!abort) begin
      case (state)
        RUN: begin
          if (run_cnt != RUN_W'(1)) run_cnt <= run_cnt - RUN_W'(1);
          settle_cnt <= settle_q - RUN_W'(1);
        end
        SETTLE: settle_cnt <= settle_cnt - RUN_W'(1);
        SAMPLE: begin
          run_cnt    <= run_q;
          last_spins <= sample_bits;
          rep_idx    <= rep_idx + REP_W'(1);
        end
        DONE: begin
          spins_q <= maj_vec;
          ties_q  <= tie_vec;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_spin
    logic [CTR_MAX-1:0] phase_full;

    assign phase_full     = phase_slice(PHASE_BUS_MAX'(phase_in), i, CTR_W);
    assign sample_bits[i] = (phase_full >= CTR_MAX'(cutoff_q));

    ising_vote_ctr #(
      .REP_W (REP_W)
    ) u_vote (
      .clk      (clk),
      .rst      (rst),
      .clear    (start_accept),
      .inc      (sample_en && sample_bits[i]),
      .reps     (reps_q),
      .majority (maj_vec[i]),
      .tie      (tie_vec[i])
    );
  end

endmodule

// File: tb/tb_ising_run_sequencer.sv
module tb_ising_run_sequencer;

  localparam int N     = 8;
  localparam int CTR_W = 8;
  localparam int RUN_W = 32;
  localparam int REP_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic [RUN_W-1:0]   cfg_run_cycles;
  logic [RUN_W-1:0]   cfg_settle_cycles;
  logic [REP_W-1:0]   cfg_reps;
  logic [CTR_W-1:0]   cfg_cutoff;
  logic [N*CTR_W-1:0] phase_in;
  logic               ising_run;
  logic               busy;
  logic               done;
  logic [N-1:0]       spins;
  logic [N-1:0]       ties;
  logic [N-1:0]       last_spins;
  logic [REP_W-1:0]   rep_idx;

  int checks = 0;
  int errors = 0;

  // Phase vector applied at the rising edge of ising_run for run 1..4.
  logic [N*CTR_W-1:0] phase_set [0:3];

  ising_run_sequencer #(
    .N     (N),
    .CTR_W (CTR_W),
    .RUN_W (RUN_W),
    .REP_W (REP_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .cfg_run_cycles    (cfg_run_cycles),
    .cfg_settle_cycles (cfg_settle_cycles),
    .cfg_reps          (cfg_reps),
    .cfg_cutoff        (cfg_cutoff),
    .phase_in          (phase_in),
    .ising_run         (ising_run),
    .busy              (busy),
    .done              (done),
    .spins             (spins),
    .ties              (ties),
    .last_spins        (last_spins),
    .rep_idx           (rep_idx)
  );

  always #5 clk = ~clk;

  // Pulses start (sampled at edge k) and watches cycles k+1.. on negedges.
  // Config inputs are scrambled after acceptance to exercise the shadow copies.
  task automatic run_job(
    input  logic [RUN_W-1:0] r,
    input  logic [RUN_W-1:0] s,
    input  logic [REP_W-1:0] reps,
    input  logic [CTR_W-1:0] cutoff,
    input  int               extra_start,
    input  int               budget,
    output int               done_cyc,
    output int               run_cycles,
    output int               rises,
    output int               min_gap,
    output int               done_cnt
  );
    logic prev;
    int   low_gap;
    cfg_run_cycles    = r;
    cfg_settle_cycles = s;
    cfg_reps          = reps;
    cfg_cutoff        = cutoff;
    done_cyc   = -1;
    run_cycles = 0;
    rises      = 0;
    min_gap    = 1000;
    done_cnt   = 0;
    prev       = 1'b0;
    low_gap    = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 2) begin
        cfg_run_cycles    = 7;
        cfg_settle_cycles = 5;
        cfg_reps          = 4'd9;
        cfg_cutoff        = 8'hFF;
      end
      if (extra_start > 0 && c == extra_start)     start = 1'b1;
      if (extra_start > 0 && c == extra_start + 1) start = 1'b0;
      if (ising_run) begin
        if (!prev) begin
          rises++;
          if (rises > 1 && low_gap < min_gap) min_gap = low_gap;
          phase_in = phase_set[(rises > 4) ? 3 : rises - 1];
        end
        run_cycles++;
        low_gap = 0;
      end else begin
        low_gap++;
      end
      prev = ising_run;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_run_cycles = '0; cfg_settle_cycles = '0; cfg_reps = '0; cfg_cutoff = '0;
    phase_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ising_run, busy, done, spins, ties, last_spins, rep_idx} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got run=%b busy=%b done=%b spins=%h ties=%h last=%h rep=%0d, expected all 0",
               ising_run, busy, done, spins, ties, last_spins, rep_idx);
    end
  endtask

  task automatic test_single_run();
    int dc, rc, ri, mg, dn;
    phase_set[0] = {8'd9, 8'd1, 8'd1, 8'd2, 8'd4, 8'd6, 8'd3, 8'd5};
    phase_set[1] = phase_set[0];
    phase_set[2] = phase_set[0];
    phase_set[3] = phase_set[0];
    run_job(4, 2, 1, 8'd4, 0, 60, dc, rc, ri, mg, dn);
    checks++;
    if (rc !== 4) begin errors++; $display("FAIL single_run_cycles: got %0d expected 4", rc); end
    checks++;
    if (dc !== 8) begin errors++; $display("FAIL single_done_cycle: got %0d expected 8", dc); end
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", dn); end
    checks++;
    if (spins !== 8'b1000_1101) begin errors++; $display("FAIL single_spins: got %b expected 10001101", spins); end
    checks++;
    if (ties !== 8'h00) begin errors++; $display("FAIL single_ties: got %b expected 00000000", ties); end
    checks++;
    if (last_spins !== 8'b1000_1101) begin errors++; $display("FAIL single_last: got %b expected 10001101", last_spins); end
    checks++;
    if (rep_idx !== 4'd1) begin errors++; $display("FAIL single_rep_idx: got %0d expected 1", rep_idx); end
  endtask

  task automatic test_three_reps();
    int dc, rc, ri, mg, dn;
    phase_set[0] = 64'd6;
    phase_set[1] = 64'd2;
    phase_set[2] = 64'd6;
    phase_set[3] = 64'd6;
    run_job(4, 2, 3, 8'd4, 0, 80, dc, rc, ri, mg, dn);
    checks++;
    if (ri !== 3) begin errors++; $display("FAIL reps3_rises: got %0d expected 3", ri); end
    checks++;
    if (mg < 3) begin errors++; $display("FAIL reps3_gap: got %0d expected >=3", mg); end
    checks++;
    if (dc !== 22) begin errors++; $display("FAIL reps3_done_cycle: got %0d expected 22", dc); end
    checks++;
    if (spins !== 8'h01) begin errors++; $display("FAIL reps3_spins: got %b expected 00000001", spins); end
    checks++;
    if (ties !== 8'h00) begin errors++; $display("FAIL reps3_ties: got %b expected 00000000", ties); end
    checks++;
    if (last_spins !== 8'h01) begin errors++; $display("FAIL reps3_last: got %b expected 00000001", last_spins); end
    checks++;
    if (rep_idx !== 4'd3) begin errors++; $display("FAIL reps3_rep_idx: got %0d expected 3", rep_idx); end
  endtask

  task automatic test_tie();
    int dc, rc, ri, mg, dn;
    phase_set[0] = 64'h0700;
    phase_set[1] = 64'h0100;
    phase_set[2] = 64'h0100;
    phase_set[3] = 64'h0100;
    run_job(4, 2, 2, 8'd4, 0, 80, dc, rc, ri, mg, dn);
    checks++;
    if (dc !== 15) begin errors++; $display("FAIL tie_done_cycle: got %0d expected 15", dc); end
    checks++;
    if (spins !== 8'h00) begin errors++; $display("FAIL tie_spins: got %b expected 00000000", spins); end
    checks++;
    if (ties !== 8'h02) begin errors++; $display("FAIL tie_ties: got %b expected 00000010", ties); end
    checks++;
    if (last_spins !== 8'h00) begin errors++; $display("FAIL tie_last: got %b expected 00000000", last_spins); end
  endtask

  task automatic test_zero_cfg();
    int dc, rc, ri, mg, dn;
    phase_set[0] = 64'h0020_0020_0020_0020;
    phase_set[1] = phase_set[0];
    phase_set[2] = phase_set[0];
    phase_set[3] = phase_set[0];
    run_job(0, 0, 0, 8'h10, 0, 40, dc, rc, ri, mg, dn);
    checks++;
    if (rc !== 1) begin errors++; $display("FAIL zero_run_cycles: got %0d expected 1", rc); end
    checks++;
    if (dc !== 3) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 3", dc); end
    checks++;
    if (spins !== 8'h55) begin errors++; $display("FAIL zero_spins: got %h expected 55", spins); end
    checks++;
    if (rep_idx !== 4'd1) begin errors++; $display("FAIL zero_rep_idx: got %0d expected 1", rep_idx); end
  endtask

  task automatic test_abort();
    int dc, rc, ri, mg, dn;
    int done_seen;
    phase_set[0] = '0;
    phase_in          = '0;
    cfg_run_cycles    = 4;
    cfg_settle_cycles = 2;
    cfg_reps          = 3;
    cfg_cutoff        = 8'd4;
    @(negedge clk);
    start = 1'b1;
    done_seen = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (done) done_seen++;
    end
    checks++;
    if (ising_run !== 1'b1) begin errors++; $display("FAIL abort_pre_run: got %b expected 1", ising_run); end
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (ising_run !== 1'b0) begin errors++; $display("FAIL abort_run_low: got %b expected 0", ising_run); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    abort = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_seen); end
    checks++;
    if (spins !== 8'h55 || ties !== 8'h00) begin
      errors++;
      $display("FAIL abort_hold: got spins=%h ties=%h expected spins=55 ties=00", spins, ties);
    end

    // Fresh job with a stray start pulse while busy.
    phase_set[0] = {8{8'd5}};
    phase_set[1] = phase_set[0];
    phase_set[2] = phase_set[0];
    phase_set[3] = phase_set[0];
    run_job(2, 1, 2, 8'd4, 3, 60, dc, rc, ri, mg, dn);
    checks++;
    if (dc !== 9) begin errors++; $display("FAIL restart_done_cycle: got %0d expected 9", dc); end
    checks++;
    if (ri !== 2 || dn !== 1) begin
      errors++;
      $display("FAIL restart_shape: got rises=%0d dones=%0d expected rises=2 dones=1", ri, dn);
    end
    checks++;
    if (spins !== 8'hFF) begin errors++; $display("FAIL restart_spins: got %h expected ff", spins); end
    checks++;
    if (rep_idx !== 4'd2) begin errors++; $display("FAIL restart_rep_idx: got %0d expected 2", rep_idx); end
  endtask

  task automatic test_mid_reset();
    int dc, rc, ri, mg, dn;
    phase_set[0] = {8'd9, 8'd1, 8'd1, 8'd2, 8'd4, 8'd6, 8'd3, 8'd5};
    phase_set[1] = phase_set[0];
    phase_set[2] = phase_set[0];
    phase_set[3] = phase_set[0];
    phase_in          = phase_set[0];
    cfg_run_cycles    = 4;
    cfg_settle_cycles = 2;
    cfg_reps          = 1;
    cfg_cutoff        = 8'd4;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || ising_run !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_in_settle: got busy=%b run=%b expected busy=1 run=0", busy, ising_run);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ising_run, busy, done, spins, ties, last_spins, rep_idx} !== '0) begin
      errors++;
      $display("FAIL mid_rst_outputs: got run=%b busy=%b done=%b spins=%h ties=%h last=%h rep=%0d, expected all 0",
               ising_run, busy, done, spins, ties, last_spins, rep_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    run_job(4, 2, 1, 8'd4, 0, 60, dc, rc, ri, mg, dn);
    checks++;
    if (dc !== 8) begin errors++; $display("FAIL post_rst_done_cycle: got %0d expected 8", dc); end
    checks++;
    if (spins !== 8'b1000_1101) begin errors++; $display("FAIL post_rst_spins: got %b expected 10001101", spins); end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_three_reps();
    test_tie();
    test_zero_cfg();
    test_abort();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
